// File: rtl/window_5x5_gen.sv
// rtl/window_5x5_gen.sv - sliding 5x5 window builder with in-image gating and end-of-frame pulse
module window_5x5_gen #(
  parameter int WIDTH  = 17,
  parameter int HEIGHT = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  input  logic [7:0]   data0_i,
  input  logic [7:0]   data1_i,
  input  logic [7:0]   data2_i,
  input  logic [7:0]   data3_i,
  input  logic [7:0]   data4_i,
  output logic [199:0] window_o,
  output logic         valid_o,
  output logic         done_o
);

  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_cnt_q, col_cnt_d;
  logic [RW-1:0] row_cnt_q, row_cnt_d;
  logic [7:0]    win_q [25];
  logic [7:0]    win_d [25];
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic [7:0]    col_in [5];
  logic          col_last, row_last, last_pix, in_image;

  // Window row 0 is the oldest image row, so it takes data4_i.
  always_comb begin
    col_in[0] = data4_i;
    col_in[1] = data3_i;
    col_in[2] = data2_i;
    col_in[3] = data1_i;
    col_in[4] = data0_i;
  end

  assign col_last = (col_cnt_q == CW'(WIDTH - 1));
  assign row_last = (row_cnt_q == RW'(HEIGHT - 1));
  assign last_pix = valid_i & col_last & row_last;
  // The first four columns of a row still hold pixels of the previous row.
  assign in_image = (col_cnt_q >= CW'(4)) && (row_cnt_q >= RW'(4));

  // Next-state: shift on accepted pixels, advance raster position, track frame phase.
  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;
    win_d     = win_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    if (valid_i) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 4; c++) begin
          win_d[r*5+c] = win_q[r*5+c+1];
        end
        win_d[r*5+4] = col_in[r];
      end
      valid_d = in_image;
      done_d  = last_pix;
      if (last_pix) begin
        // Counters clear so a pixel arriving during DONE starts the next frame at (0,0).
        col_cnt_d = '0;
        row_cnt_d = '0;
        state_d   = DONE;
      end else if (col_last) begin
        col_cnt_d = '0;
        row_cnt_d = row_cnt_q + 1'b1;
        state_d   = ACTIVE;
      end else begin
        col_cnt_d = col_cnt_q + 1'b1;
        state_d   = ACTIVE;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end

  // State registers; a reset mid-frame drops the partial frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      col_cnt_q <= '0;
      row_cnt_q <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < 25; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      row_cnt_q <= row_cnt_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      win_q     <= win_d;
    end
  end

  for (genvar i = 0; i < 25; i++) begin : g_pack
    assign window_o[8*i +: 8] = win_q[i];
  end

  assign valid_o = valid_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_window_5x5_gen.sv
// tb/tb_window_5x5_gen.sv - scoreboard bench for window_5x5_gen at 8x6 and default 17x17
module tb_window_5x5_gen;

  logic         clk = 1'b0;
  logic         rst_s, rst_b, valid_i;
  logic [7:0]   d0, d1, d2, d3, d4;
  logic [199:0] win_s, win_b;
  logic         vo_s, vo_b, do_s, do_b;
  logic         sel_big;

  always #5 clk = ~clk;

  window_5x5_gen #(.WIDTH(8), .HEIGHT(6)) u_small (
    .clk(clk), .rst(rst_s), .valid_i(valid_i),
    .data0_i(d0), .data1_i(d1), .data2_i(d2), .data3_i(d3), .data4_i(d4),
    .window_o(win_s), .valid_o(vo_s), .done_o(do_s)
  );

  window_5x5_gen u_big (
    .clk(clk), .rst(rst_b), .valid_i(valid_i),
    .data0_i(d0), .data1_i(d1), .data2_i(d2), .data3_i(d3), .data4_i(d4),
    .window_o(win_b), .valid_o(vo_b), .done_o(do_b)
  );

  wire [199:0] win_o = sel_big ? win_b : win_s;
  wire         vo    = sel_big ? vo_b  : vo_s;
  wire         dn    = sel_big ? do_b  : do_s;

  typedef struct {
    logic [199:0] win;
    logic         done;
  } exp_t;

  typedef struct {
    int         idx;
    logic [7:0] b0;
    logic [7:0] b12;
    logic [7:0] b24;
    logic       done;
  } vec_t;

  exp_t         exp_q[$];
  logic [199:0] caps[$];
  logic         cap_done[$];
  logic [199:0] ref_caps[$];
  vec_t         vt[4];
  int n_chk = 0, n_fail = 0;
  int cur_w, cur_h, mr, mc, frame_acc, wins, dones;
  bit b2b;

  function automatic logic [7:0] pix(int row, int col);
    return 8'(row * 16 + col);
  endfunction

  task automatic check(string name, logic [199:0] act, logic [199:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mr = 0; mc = 0; frame_acc = 0;
    wins = 0; dones = 0; b2b = 0;
    exp_q.delete(); caps.delete(); cap_done.delete();
  endtask

  task automatic monitor();
    exp_t e;
    if (vo) begin
      wins++;
      if (dn) dones++;
      caps.push_back(win_o);
      cap_done.push_back(dn);
      if (exp_q.size() == 0) begin
        check("unexpected_window", 200'(vo), 200'(0));
      end else begin
        e = exp_q.pop_front();
        check("window", win_o, e.win);
        check("done_flag", 200'(dn), 200'(e.done));
        if (b2b && wins == 9) check("frame2_first_window_pos", 200'(frame_acc), 200'(37));
      end
    end else begin
      check("done_without_valid", 200'(dn), 200'(0));
      if (exp_q.size() != 0) begin
        check("missing_window", 200'(vo), 200'(1));
        void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic step(bit v);
    exp_t e;
    valid_i = v;
    if (v) begin
      if (mr == 0 && mc == 0) frame_acc = 0;
      frame_acc++;
      d0 = pix(mr, mc);     d1 = pix(mr - 1, mc); d2 = pix(mr - 2, mc);
      d3 = pix(mr - 3, mc); d4 = pix(mr - 4, mc);
      if (mr >= 4 && mc >= 4) begin
        e.win = '0;
        for (int rr = 0; rr < 5; rr++)
          for (int cc = 0; cc < 5; cc++)
            e.win[8*(rr*5+cc) +: 8] = pix(mr - 4 + rr, mc - 4 + cc);
        e.done = (mr == cur_h - 1) && (mc == cur_w - 1);
        exp_q.push_back(e);
      end
      if (mc == cur_w - 1) begin
        mc = 0;
        mr = (mr == cur_h - 1) ? 0 : mr + 1;
      end else begin
        mc++;
      end
    end else begin
      d0 = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom);
      d3 = 8'($urandom); d4 = 8'($urandom);
    end
    @(posedge clk);
    #1;
    monitor();
  endtask

  initial begin
    vt[0] = '{0, 8'h00, 8'h22, 8'h44, 1'b0};
    vt[1] = '{3, 8'h03, 8'h25, 8'h47, 1'b0};
    vt[2] = '{4, 8'h10, 8'h32, 8'h54, 1'b0};
    vt[3] = '{7, 8'h13, 8'h35, 8'h57, 1'b1};

    rst_s = 1'b0; rst_b = 1'b0; valid_i = 1'b0; sel_big = 1'b0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0; d4 = '0;
    cur_w = 8; cur_h = 6;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_window", win_s, '0);
    check("reset_valid", 200'(vo_s), 200'(0));
    check("reset_done", 200'(do_s), 200'(0));
    check("reset_big_window", win_b, '0);
    rst_s = 1'b1;

    // reset mid-frame
    repeat (20) step(1'b1);
    rst_s = 1'b0;
    #1;
    check("midreset_window", win_s, '0);
    check("midreset_valid", 200'(vo_s), 200'(0));
    check("midreset_done", 200'(do_s), 200'(0));
    @(posedge clk);
    #1;
    rst_s = 1'b1;
    model_reset();
    repeat (48) step(1'b1);
    repeat (2) step(1'b0);
    check("postreset_windows", 200'(wins), 200'(8));
    check("postreset_dones", 200'(dones), 200'(1));

    // continuous frame with table of known windows
    model_reset();
    repeat (48) step(1'b1);
    repeat (2) step(1'b0);
    check("cont_windows", 200'(wins), 200'(8));
    check("cont_dones", 200'(dones), 200'(1));
    if (caps.size() == 8) begin
      for (int i = 0; i < 4; i++) begin
        check("tbl_byte0",  200'(caps[vt[i].idx][7:0]),     200'(vt[i].b0));
        check("tbl_byte12", 200'(caps[vt[i].idx][103:96]),  200'(vt[i].b12));
        check("tbl_byte24", 200'(caps[vt[i].idx][199:192]), 200'(vt[i].b24));
        check("tbl_done",   200'(cap_done[vt[i].idx]),      200'(vt[i].done));
      end
    end
    ref_caps = caps;

    // gapped input
    model_reset();
    for (int i = 0; i < 48; i++) begin
      step(1'b1);
      step(1'b0);
    end
    check("gap_windows", 200'(wins), 200'(8));
    check("gap_dones", 200'(dones), 200'(1));
    if (caps.size() == 8 && ref_caps.size() == 8)
      for (int i = 0; i < 8; i++) check("gap_same_window", caps[i], ref_caps[i]);

    // back-to-back frames, second starts in the DONE cycle
    model_reset();
    b2b = 1'b1;
    repeat (96) step(1'b1);
    repeat (2) step(1'b0);
    check("b2b_windows", 200'(wins), 200'(16));
    check("b2b_dones", 200'(dones), 200'(2));

    // default 17x17 ramp
    sel_big = 1'b1;
    rst_b = 1'b1;
    cur_w = 17; cur_h = 17;
    model_reset();
    repeat (289) step(1'b1);
    repeat (2) step(1'b0);
    check("big_windows", 200'(wins), 200'(169));
    check("big_dones", 200'(dones), 200'(1));
    if (caps.size() == 169) begin
      check("big_first_byte0",  200'(caps[0][7:0]),       200'(8'h00));
      check("big_first_byte24", 200'(caps[0][199:192]),   200'(8'h44));
      check("big_last_byte0",   200'(caps[168][7:0]),     200'(8'hCC));
      check("big_last_byte24",  200'(caps[168][199:192]), 200'(8'h10));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
